// File: rtl/kore_funcfsm_seq.sv
// kore_funcfsm_seq: multi-cycle regbank read / execute / write-back sequencer.
// Optional zero/carry/overflow flag outputs are enabled by defining KORE_FUNC_FLAGS_EN.
module kore_funcfsm_seq #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int RD_LAT       = 1,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          opflag,
    input  logic [6:0]    opcode,
    input  logic [AW-1:0] pcdata_rs0,
    input  logic [AW-1:0] pcdata_rs1,
    input  logic [AW-1:0] pcdata_rd,
    input  logic [DW-1:0] data_bus,
    output logic [AW-1:0] reg_sel,
    output logic          reg_rd,
    output logic [DW-1:0] data_out,
    output logic          wt_en,
    output logic          eop,
    output logic          busy,
`ifdef KORE_FUNC_FLAGS_EN
    output logic          illegal,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_v
`else
    output logic          illegal
`endif
);
    localparam logic [6:0] OP_DEC = 7'h08;
    typedef enum logic [2:0] {IDLE, RS0, RS1, EXEC, WB} state_t;
    state_t          r_state;
    logic [6:0]      r_op;
    logic [AW-1:0]   r_rs1;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [2:0]      r_cnt;
    logic [DW-1:0]   w_mul;
    logic [DW-1:0]   w_res;
    logic            w_legal;
`ifdef KORE_FUNC_FLAGS_EN
    logic [2*DW-1:0] w_prod;
    assign w_prod = {{DW{1'b0}}, r_a} * {{DW{1'b0}}, r_b};
    assign w_mul  = w_prod[DW-1:0];
`else
    assign w_mul  = r_a * r_b;
`endif
    // every opcode bit selects exactly one operation, so legality is just one-hotness
    assign w_legal = $onehot(r_op);
    assign w_res   = r_op[0] ? w_mul :
                     r_op[1] ? r_a + r_b :
                     r_op[2] ? r_a - r_b :
                     r_op[3] ? r_a - DW'(1) :
                     r_op[4] ? r_a & r_b :
                     r_op[5] ? r_a | r_b : r_a ^ r_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rs1    <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            reg_sel  <= '0;
            reg_rd   <= 1'b0;
            data_out <= '0;
            wt_en    <= 1'b0;
            eop      <= 1'b0;
            busy     <= 1'b0;
            illegal  <= 1'b0;
`ifdef KORE_FUNC_FLAGS_EN
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (opflag) begin
                    r_state <= RS0;
                    r_op    <= opcode;
                    r_rs1   <= pcdata_rs1;
                    r_rd    <= pcdata_rd;
                    reg_sel <= pcdata_rs0;
                    reg_rd  <= 1'b1;
                    busy    <= 1'b1;
                    r_cnt   <= 3'(RD_LAT);
                end
                RS0: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                else begin
                    r_a   <= data_bus;
                    r_cnt <= 3'(RD_LAT);
                    if (r_op == OP_DEC) begin
                        r_state <= EXEC;
                        reg_rd  <= 1'b0;
                    end else begin
                        r_state <= RS1;
                        reg_sel <= r_rs1;
                    end
                end
                RS1: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                else begin
                    r_b     <= data_bus;
                    r_state <= EXEC;
                    reg_rd  <= 1'b0;
                end
                EXEC: begin
                    r_state  <= WB;
                    eop      <= 1'b1;
                    illegal  <= !w_legal;
                    wt_en    <= w_legal && !(R0_HARDWIRED && r_rd == '0);
                    data_out <= w_legal ? w_res : '0;
                    reg_sel  <= r_rd;
`ifdef KORE_FUNC_FLAGS_EN
                    if (w_legal) begin
                        flag_z <= w_res == '0;
                        flag_c <= r_op[1] ? w_res < r_a : r_op[2] ? r_a < r_b : r_op[3] && r_a == '0;
                        flag_v <= r_op[0] && |w_prod[2*DW-1:DW];
                    end
`endif
                end
                WB: begin
                    r_state <= IDLE;
                    eop     <= 1'b0;
                    wt_en   <= 1'b0;
                    illegal <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kore_funcfsm_seq.sv
// tb_kore_funcfsm_seq: drives two sequencer configurations (RD_LAT=1 r0-hardwired, RD_LAT=3 not)
// with directed and random operations, checked against a behavioural model.
module tb_kore_funcfsm_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opflag = 1'b0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rs0 = '0, rs1 = '0, rd = '0;
    logic [31:0] regs [32];
    logic [31:0] data_bus [2];
    logic [4:0]  reg_sel [2];
    logic [31:0] data_out [2];
    logic [1:0]  reg_rd, wt_en, eop, busy, illegal;
    logic [31:0] pa = '0;
    logic [31:0] pb [3] = '{32'h0, 32'h0, 32'h0};
    int          n_chk = 0, n_err = 0;
`ifdef KORE_FUNC_FLAGS_EN
    logic [1:0]  flag_z, flag_c, flag_v;
    logic [2:0]  ef [2] = '{3'b0, 3'b0};
`endif

    always #5 clk = ~clk;

    // regbank models: data appears RD_LAT cycles after the address is presented
    always @(posedge clk) begin
        pa    <= regs[reg_sel[0]];
        pb[0] <= regs[reg_sel[1]];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign data_bus[0] = pa;
    assign data_bus[1] = pb[2];

    kore_funcfsm_seq #(.DW(32), .AW(5), .RD_LAT(1), .R0_HARDWIRED(1'b1)) u_a (
        .clk(clk), .rst(rst), .opflag(opflag), .opcode(opcode),
        .pcdata_rs0(rs0), .pcdata_rs1(rs1), .pcdata_rd(rd), .data_bus(data_bus[0]),
        .reg_sel(reg_sel[0]), .reg_rd(reg_rd[0]), .data_out(data_out[0]), .wt_en(wt_en[0]),
        .eop(eop[0]), .busy(busy[0]),
`ifdef KORE_FUNC_FLAGS_EN
        .flag_z(flag_z[0]), .flag_c(flag_c[0]), .flag_v(flag_v[0]),
`endif
        .illegal(illegal[0]));

    kore_funcfsm_seq #(.DW(32), .AW(5), .RD_LAT(3), .R0_HARDWIRED(1'b0)) u_b (
        .clk(clk), .rst(rst), .opflag(opflag), .opcode(opcode),
        .pcdata_rs0(rs0), .pcdata_rs1(rs1), .pcdata_rd(rd), .data_bus(data_bus[1]),
        .reg_sel(reg_sel[1]), .reg_rd(reg_rd[1]), .data_out(data_out[1]), .wt_en(wt_en[1]),
        .eop(eop[1]), .busy(busy[1]),
`ifdef KORE_FUNC_FLAGS_EN
        .flag_z(flag_z[1]), .flag_c(flag_c[1]), .flag_v(flag_v[1]),
`endif
        .illegal(illegal[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            7'h01:   ref_op = {1'b1, a * b};
            7'h02:   ref_op = {1'b1, a + b};
            7'h04:   ref_op = {1'b1, a - b};
            7'h08:   ref_op = {1'b1, a - 32'd1};
            7'h10:   ref_op = {1'b1, a & b};
            7'h20:   ref_op = {1'b1, a | b};
            7'h40:   ref_op = {1'b1, a ^ b};
            default: ref_op = 33'h0;
        endcase
    endfunction

`ifdef KORE_FUNC_FLAGS_EN
    function automatic logic [2:0] ref_flags(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r = ref_op(op, a, b);
        logic [32:0] s = {1'b0, a} + {1'b0, b};
        logic [63:0] p = {32'h0, a} * {32'h0, b};
        logic        c = op == 7'h02 ? s[32] : op == 7'h04 ? a < b : op == 7'h08 ? a == 32'h0 : 1'b0;
        ref_flags = {r[31:0] == 32'h0, c, op == 7'h01 && p[63:32] != 32'h0};
    endfunction
`endif

    function automatic int exp_lat(input int i, input logic [6:0] op);
        int l = i == 0 ? 1 : 3;
        exp_lat = op == 7'h08 ? l + 3 : 2 * l + 4;
    endfunction

    task automatic run_op(input logic [6:0] op, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] d, input bit scramble);
        logic [31:0] a = regs[s0];
        logic [31:0] b = regs[s1];
        logic [32:0] r = ref_op(op, a, b);
        int  lat [2] = '{0, 0};
        bit  done [2] = '{1'b0, 1'b0};
        bit  bsy_ok [2] = '{1'b1, 1'b1};
        bit  stray [2] = '{1'b0, 1'b0};
        bit  rs1_rd [2] = '{1'b0, 1'b0};
        @(negedge clk);
        opflag = 1'b1; opcode = op; rs0 = s0; rs1 = s1; rd = d;
        @(negedge clk);
        opflag = 1'b0;
        if (scramble) begin
            opcode = 7'($urandom); rs0 = 5'($urandom); rs1 = 5'($urandom); rd = 5'($urandom);
        end
        for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
            if (c > 1) @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    if (eop[i] || wt_en[i] || illegal[i]) stray[i] = 1'b1;
                end else begin
                    if (!busy[i]) bsy_ok[i] = 1'b0;
                    if (reg_rd[i] && reg_sel[i] == s1) rs1_rd[i] = 1'b1;
                    if (eop[i]) begin
                        done[i] = 1'b1;
                        lat[i] = c;
                        chk($sformatf("data%0d op%0h", i, op), data_out[i], r[32] ? r[31:0] : 32'h0);
                        chk($sformatf("wt_en%0d op%0h rd%0d", i, op, d), 32'(wt_en[i]),
                            32'(r[32] && !(i == 0 && d == 5'd0)));
                        chk($sformatf("sel%0d", i), 32'(reg_sel[i]), 32'(d));
                        chk($sformatf("illegal%0d op%0h", i, op), 32'(illegal[i]), 32'(!r[32]));
`ifdef KORE_FUNC_FLAGS_EN
                        if (r[32]) ef[i] = ref_flags(op, a, b);
                        chk($sformatf("flags%0d op%0h", i, op), 32'({flag_z[i], flag_c[i], flag_v[i]}), 32'(ef[i]));
`endif
                    end else if (wt_en[i] || illegal[i]) stray[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (eop[i] || wt_en[i] || illegal[i]) stray[i] = 1'b1;
            chk($sformatf("lat%0d op%0h", i, op), 32'(lat[i]), 32'(exp_lat(i, op)));
            chk($sformatf("busy%0d", i), 32'(bsy_ok[i]), 32'd1);
            chk($sformatf("stray%0d", i), 32'(stray[i]), 32'd0);
            chk($sformatf("idle%0d", i), 32'(busy[i]), 32'd0);
            if (op == 7'h08 && s0 != s1) chk($sformatf("dec_rs1_%0d", i), 32'(rs1_rd[i]), 32'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_ctl%0d", tag, i), 32'({busy[i], eop[i], wt_en[i], reg_rd[i], illegal[i]}), 32'd0);
            chk($sformatf("%s_sel%0d", tag, i), 32'(reg_sel[i]), 32'd0);
            chk($sformatf("%s_data%0d", tag, i), data_out[i], 32'd0);
        end
    endtask

    task automatic back_to_back();
        int last = -1, idle = 0, pulses = 0;
        regs[1] = 32'd5; regs[2] = 32'd7;
        @(negedge clk);
        opflag = 1'b1; opcode = 7'h02; rs0 = 5'd1; rs1 = 5'd2; rd = 5'd3;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!busy[0]) idle++;
            if (eop[0]) begin
                chk("b2b_data", data_out[0], 32'd12);
                if (last >= 0) begin
                    chk("b2b_period", 32'(c - last), 32'd7);
                    chk("b2b_idle", 32'(idle), 32'd1);
                end
                last = c; idle = 0; pulses++;
            end
        end
        opflag = 1'b0;
        chk("b2b_pulses", 32'(pulses), 32'd5);
        for (int c = 0; c < 40 && busy != 2'b00; c++) @(negedge clk);
        chk("b2b_drain", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_op();
        int bad = 0;
        regs[1] = 32'd5; regs[2] = 32'd7;
        @(negedge clk);
        opflag = 1'b1; opcode = 7'h02; rs0 = 5'd1; rs1 = 5'd2; rd = 5'd3;
        @(negedge clk);
        opflag = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef KORE_FUNC_FLAGS_EN
        ef = '{3'b0, 3'b0};
`endif
        chk_zero("midrst");
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (wt_en != 2'b00 || eop != 2'b00) bad++;
        end
        chk("midrst_no_wb", 32'(bad), 32'd0);
    endtask

    initial begin
        logic [6:0] op;
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        regs[1] = 32'd5; regs[2] = 32'd7;
        run_op(7'h02, 5'd1, 5'd2, 5'd3, 1'b1);
        regs[1] = 32'd0; regs[2] = 32'd1;
        run_op(7'h04, 5'd1, 5'd2, 5'd4, 1'b0);
        run_op(7'h08, 5'd1, 5'd2, 5'd5, 1'b0);
        regs[1] = 32'h10000; regs[2] = 32'h10000;
        run_op(7'h01, 5'd1, 5'd2, 5'd6, 1'b0);
        run_op(7'h03, 5'd1, 5'd2, 5'd7, 1'b0);
        regs[1] = 32'd5; regs[2] = 32'd7;
        run_op(7'h02, 5'd1, 5'd2, 5'd3, 1'b0);
        run_op(7'h02, 5'd1, 5'd2, 5'd0, 1'b0);
        run_op(7'h00, 5'd1, 5'd2, 5'd9, 1'b0);
        run_op(7'h7f, 5'd1, 5'd2, 5'd9, 1'b0);
        back_to_back();
        reset_mid_op();
        run_op(7'h02, 5'd1, 5'd2, 5'd3, 1'b0);
        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 32; r++) regs[r] = $urandom;
            op = $urandom_range(0, 4) != 0 ? 7'(1 << $urandom_range(0, 6)) : 7'($urandom);
            run_op(op, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/kore_funcfsm_seq.md
Name: kore_funcfsm_seq

Overview:
Parametrised, multi-cycle register-to-register execution sequencer for the kore datapath.
- On an accepted `opflag` it latches the instruction fields and reads rs0 (and rs1 when needed) from kore_regbank over the shared `reg_sel`/`data_bus` port.
- It then computes the result, writes it back to rd, and pulses `eop`.
- It generalises the original functional FSM: configurable data/address width and regbank read latency, an extended opcode set, illegal-opcode reporting, a busy handshake and an optional r0-hardwired guard.

Parameters:
DW, 32, data width of regbank words and ALU.
AW, 5, register address width.
RD_LAT, 1, regbank read latency in cycles (1..4); `data_bus` is valid RD_LAT cycles after `reg_sel`/`reg_rd` are presented.
R0_HARDWIRED, 1, when 1 a write targeting rd==0 is suppressed (`wt_en` stays 0; `eop` still pulses).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
opflag  in  1  start request; sampled only in IDLE.
opcode  in  7  operation select (one-hot, see Behaviour).
pcdata_rs0  in  AW  source register 0 address.
pcdata_rs1  in  AW  source register 1 address.
pcdata_rd  in  AW  destination register address.
data_bus  in  DW  read data from kore_regbank.
reg_sel  out  AW  register address to kore_regbank.
reg_rd  out  1  read strobe to kore_regbank.
data_out  out  DW  write data to kore_regbank.
wt_en  out  1  write enable to kore_regbank.
eop  out  1  end-of-operation, one-cycle pulse.
busy  out  1  high from acceptance through the `eop` cycle.
illegal  out  1  one-cycle pulse coincident with `eop` for an unsupported opcode.

Behaviour:
- Clocking and reset:
  - Single clock domain; rst is synchronous and active-high.
  - All outputs are registered; all reset to 0 and the FSM resets to IDLE.
  - rst asserted mid-operation: the FSM returns to IDLE at that edge, no write occurs, and any in-flight operation is discarded.
- States: IDLE, RS0, RS1, EXEC, WB.
- IDLE:
  - busy=0. `opflag`=1 at an edge = acceptance.
  - At acceptance, opcode, rs0, rs1 and rd are latched; input changes after acceptance are ignored.
  - Next state is RS0.
- RS0:
  - Lasts RD_LAT+1 cycles with reg_sel=rs0 and reg_rd=1; an internal counter counts RD_LAT..0.
  - `data_bus` is captured into operand A on the final cycle.
  - Next state is RS1, or EXEC if the opcode is DEC.
- RS1:
  - Same timing as RS0, with reg_sel=rs1; `data_bus` is captured into operand B.
  - Next state is EXEC.
- EXEC: 1 cycle, reg_rd=0, result computed into a register. Next state is WB.
- WB:
  - 1 cycle: eop=1, data_out=result, reg_sel=rd.
  - wt_en=1 unless the opcode is illegal, or R0_HARDWIRED=1 and rd==0.
  - Next state is IDLE; a new `opflag` is accepted no earlier than the cycle after WB.
- Latency from the acceptance edge to eop high:
  - 2·(RD_LAT+1)+2 cycles (6 at RD_LAT=1).
  - DEC: RD_LAT+3 cycles.
- `opflag` while busy is ignored (no queueing).
- Opcodes (ALU results computed modulo 2^DW):

  | opcode | operation |
  |---|---|
  | 0x01 MUL | A·B, lower DW bits |
  | 0x02 ADD | A+B |
  | 0x04 SUB | A−B, wraps |
  | 0x08 DEC | A−1; 0 → all-ones |
  | 0x10 AND | A&B |
  | 0x20 OR | A\|B |
  | 0x40 XOR | A^B |

  - Any other value, including 0 and multi-hot values, is illegal.
- Illegal opcode:
  - Still performs the RS0/RS1 reads.
  - In WB: wt_en=0, data_out=0, eop=1, illegal=1.
- Outside WB: eop=0, wt_en=0, illegal=0; data_out holds its last value.
- reg_sel holds its last value in IDLE after the first op.

Optional Feature:
KORE_FUNC_FLAGS_EN:
- Defined: adds outputs `flag_z` (1), `flag_c` (1) and `flag_v` (1), registered and updated only in WB of a legal op.
  - flag_z = result==0.
  - flag_c = carry-out for ADD; borrow for SUB/DEC.
  - flag_v = MUL upper DW bits nonzero.
  - All other ops clear flag_c and flag_v.
  - All three flags reset to 0.
- Undefined: the ports do not exist; no flag logic is present.

Test Plan:
1. ADD (DW=32, RD_LAT=1): regs r1=5, r2=7; opflag with opcode=0x02, rs0=1, rs1=2, rd=3 → eop, wt_en=1, reg_sel=3, data_out=12 on the 6th edge after acceptance; busy=1 throughout.
2. Wrap cases: SUB r1=0, r2=1 → data_out=0xFFFFFFFF. DEC r1=0 → 0xFFFFFFFF, eop at RD_LAT+3 cycles, no rs1 read (reg_rd never presents rs1). MUL 0x10000·0x10000 → 0 (flag_v=1 when KORE_FUNC_FLAGS_EN is defined).
3. Illegal opcode=0x03 → eop=1, illegal=1, wt_en=0 for exactly one cycle; FSM returns to IDLE and the next ADD completes normally.
4. R0_HARDWIRED=1, ADD with rd=0 → eop=1, wt_en=0; with R0_HARDWIRED=0 → wt_en=1, reg_sel=0.
5. opflag held high continuously → ops complete back-to-back with one IDLE cycle between eop pulses; opcode changes during busy have no effect on the result.
6. rst asserted during RS1 → next cycle all outputs 0, FSM in IDLE, no wt_en pulse; RD_LAT=3 run of scenario 1 → eop at the 10th edge, data still 12.
